// File: rtl/l1_nway_instr_cache.sv
// N-way set-associative L1 instruction cache. Hits return in the same cycle.
// A miss refills the whole line one word per memory beat, replacing the
// lowest-index invalid way or, when the set is full, the true-LRU way.
module l1_nway_instr_cache #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_SETS       = 64,
   parameter int NUM_WAYS       = 4,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic                  flush_i,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic                  instr_valid_o,
   output logic                  stall_o,
   output logic                  mem_req_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic [DATA_WIDTH-1:0] mem_data_i,
   input  logic                  mem_valid_i
);

   localparam int WOFF_BITS = $clog2(WORDS_PER_LINE);
   localparam int IDX_BITS  = $clog2(NUM_SETS);
   localparam int TAG_BITS  = ADDR_WIDTH - IDX_BITS - WOFF_BITS - 2;
   localparam int LINE_BITS = ADDR_WIDTH - WOFF_BITS - 2;   // tag + index
   localparam int CNT_BITS  = (WOFF_BITS > 0) ? WOFF_BITS : 1;
   localparam int AGE_BITS  = $clog2(NUM_WAYS);
   localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WORDS_PER_LINE - 1);

   typedef enum logic [0:0] {IDLE, REFILL} state_t;

   state_t                 state_reg, state_next;
   logic [CNT_BITS-1:0]    cnt_reg, cnt_next;
   logic [LINE_BITS-1:0]   base_reg, base_next;
   logic [IDX_BITS-1:0]    idx_reg, idx_next;
   logic [AGE_BITS-1:0]    victim_reg, victim_next;

   // Valid bits and ages are flops (one-cycle flush, per-set LRU update);
   // tags and data are plain storage arrays that are never reset.
   logic                   valid_reg  [NUM_SETS][NUM_WAYS];
   logic                   valid_next [NUM_SETS][NUM_WAYS];
   logic [AGE_BITS-1:0]    age_reg    [NUM_SETS][NUM_WAYS];
   logic [AGE_BITS-1:0]    age_next   [NUM_SETS][NUM_WAYS];
   logic [AGE_BITS-1:0]    age_init   [NUM_SETS][NUM_WAYS];
   logic [TAG_BITS-1:0]    tag_mem    [NUM_SETS][NUM_WAYS];
   logic [DATA_WIDTH-1:0]  data_mem   [NUM_SETS][NUM_WAYS][WORDS_PER_LINE];

   logic [TAG_BITS-1:0]    req_tag;
   logic [IDX_BITS-1:0]    req_idx;
   logic [CNT_BITS-1:0]    req_off;
   logic [NUM_WAYS-1:0]    way_match;
   logic [AGE_BITS-1:0]    hit_way, victim_sel, touch_way, touch_age;
   logic [IDX_BITS-1:0]    touch_set;
   logic                   hit, start_refill, beat, install, touch_en;
   logic                   unused_addr_bits;

   assign unused_addr_bits = &{1'b0, addr_i[1:0]};
   assign req_tag = addr_i[ADDR_WIDTH-1 -: TAG_BITS];
   assign req_idx = addr_i[WOFF_BITS+2 +: IDX_BITS];

   generate
      if (WOFF_BITS > 0) begin : g_off
         assign req_off = addr_i[2 +: WOFF_BITS];
      end else begin : g_no_off
         assign req_off = '0;
      end
   endgenerate

   genvar gi, gj;
   generate
      for (gj = 0; gj < NUM_WAYS; gj++) begin : g_match
         assign way_match[gj] = valid_reg[req_idx][gj] && (tag_mem[req_idx][gj] == req_tag);
      end
   endgenerate

   assign hit           = (state_reg == IDLE) && req_valid_i && (|way_match);
   assign instr_valid_o = hit;
   assign instr_o       = hit ? data_mem[req_idx][hit_way][req_off] : DATA_WIDTH'(32'hDEADBEEF);
   assign stall_o       = (state_reg == REFILL) || (req_valid_i && !hit);
   assign mem_addr_o    = {base_reg, {(WOFF_BITS+2){1'b0}}} | (ADDR_WIDTH'(cnt_reg) << 2);
   assign touch_age     = age_reg[touch_set][touch_way];

   // Hit-way encode and victim choice: lowest invalid way, else the oldest way
   always_comb begin
      hit_way    = '0;
      victim_sel = '0;
      for (int w = NUM_WAYS-1; w >= 0; w--) begin
         if (way_match[w]) hit_way = AGE_BITS'(w);
         if (age_reg[req_idx][w] == AGE_BITS'(NUM_WAYS-1)) victim_sel = AGE_BITS'(w);
      end
      for (int w = NUM_WAYS-1; w >= 0; w--) begin
         if (!valid_reg[req_idx][w]) victim_sel = AGE_BITS'(w);
      end
   end

   // Refill FSM next state, memory request and datapath strobes
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      base_next    = base_reg;
      idx_next     = idx_reg;
      victim_next  = victim_reg;
      mem_req_o    = 1'b0;
      start_refill = 1'b0;
      beat         = 1'b0;
      install      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req_valid_i && !hit && !flush_i) begin
               state_next   = REFILL;
               base_next    = addr_i[ADDR_WIDTH-1 -: LINE_BITS];
               idx_next     = req_idx;
               victim_next  = victim_sel;
               cnt_next     = '0;
               start_refill = 1'b1;
            end
         end
         REFILL: begin
            mem_req_o = 1'b1;
            if (flush_i) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (mem_valid_i) begin
               beat = 1'b1;
               if (cnt_reg == LAST_CNT) begin
                  install    = 1'b1;
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // LRU touch source: a clean hit, else a line install; flush suppresses both
   always_comb begin
      touch_en  = 1'b0;
      touch_set = req_idx;
      touch_way = hit_way;
      if (!flush_i) begin
         if (hit) begin
            touch_en = 1'b1;
         end else if (install) begin
            touch_en  = 1'b1;
            touch_set = idx_reg;
            touch_way = victim_reg;
         end
      end
   end

   generate
      for (gi = 0; gi < NUM_SETS; gi++) begin : g_set
         for (gj = 0; gj < NUM_WAYS; gj++) begin : g_way
            assign age_init[gi][gj] = AGE_BITS'(gj);
            assign valid_next[gi][gj] =
               flush_i ? 1'b0 :
               (start_refill && req_idx == IDX_BITS'(gi) && victim_sel == AGE_BITS'(gj)) ? 1'b0 :
               (install && idx_reg == IDX_BITS'(gi) && victim_reg == AGE_BITS'(gj)) ? 1'b1 :
               valid_reg[gi][gj];
            assign age_next[gi][gj] =
               !(touch_en && touch_set == IDX_BITS'(gi)) ? age_reg[gi][gj] :
               (touch_way == AGE_BITS'(gj)) ? '0 :
               (age_reg[gi][gj] < touch_age) ? age_reg[gi][gj] + 1'b1 :
               age_reg[gi][gj];
         end
      end
   endgenerate

   // FSM state and miss-time latches
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         base_reg   <= '0;
         idx_reg    <= '0;
         victim_reg <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         base_reg   <= base_next;
         idx_reg    <= idx_next;
         victim_reg <= victim_next;
      end
   end

   // Valid bits and LRU ages; reset makes way w have age w in every set
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg <= '{default: '0};
         age_reg   <= age_init;
      end else begin
         valid_reg <= valid_next;
         age_reg   <= age_next;
      end
   end

   // Refill writes: one data word per beat, tag on the final beat
   always_ff @(posedge clk) begin
      if (beat) data_mem[idx_reg][victim_reg][cnt_reg] <= mem_data_i;
      if (install) tag_mem[idx_reg][victim_reg] <= base_reg[LINE_BITS-1 -: TAG_BITS];
   end

endmodule

// File: tb/tb_l1_nway_instr_cache.sv
// Randomised scoreboard bench for l1_nway_instr_cache with a recency-list
// reference model; memory returns addr ^ 32'hA5A5_0000.
module tb_l1_nway_instr_cache;

   localparam int NS  = 64;
   localparam int NW  = 4;
   localparam int WPL = 4;

   logic        clk, rst, req_valid_i, flush_i, mem_valid_i;
   logic [31:0] addr_i, instr_o, mem_addr_o, mem_data_i;
   logic        instr_valid_o, stall_o, mem_req_o;

   l1_nway_instr_cache dut (
      .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .addr_i(addr_i), .flush_i(flush_i),
      .instr_o(instr_o), .instr_valid_o(instr_valid_o), .stall_o(stall_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
      .mem_valid_i(mem_valid_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_data_i = mem_addr_o ^ 32'hA5A5_0000;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } sb_t;

   sb_t         sb_q[$];
   logic [31:0] maddr_q[$];
   int          checks = 0;
   int          failures = 0;
   int          mem_mode = 0;   // 0: no waits, 1: valid every third cycle, 2: random
   int          wcnt = 0;

   // Reference model: per set, valid/tag per way and a recency list (index 0 = MRU)
   bit          m_valid [NS][NW];
   logic [21:0] m_tag   [NS][NW];
   int          m_order [NS][NW];

   function automatic void model_reset();
      for (int s = 0; s < NS; s++)
         for (int i = 0; i < NW; i++) begin
            m_valid[s][i] = 1'b0;
            m_order[s][i] = i;
         end
   endfunction

   function automatic void model_flush();
      for (int s = 0; s < NS; s++)
         for (int i = 0; i < NW; i++) m_valid[s][i] = 1'b0;
   endfunction

   function automatic void model_touch(int s, int w);
      int p = 0;
      for (int i = 0; i < NW; i++) if (m_order[s][i] == w) p = i;
      for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
      m_order[s][0] = w;
   endfunction

   function automatic bit model_access(input logic [31:0] a);
      int s = int'(a[9:4]);
      int victim;
      for (int w = 0; w < NW; w++)
         if (m_valid[s][w] && m_tag[s][w] == a[31:10]) begin
            model_touch(s, w);
            return 1'b1;
         end
      victim = m_order[s][NW-1];
      for (int w = NW-1; w >= 0; w--) if (!m_valid[s][w]) victim = w;
      m_valid[s][victim] = 1'b1;
      m_tag[s][victim]   = a[31:10];
      model_touch(s, victim);
      return 1'b0;
   endfunction

   // Memory responder: drives mem_valid_i according to the current wait mode
   initial begin
      mem_valid_i = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (mem_mode)
            0: mem_valid_i = 1'b1;
            1: begin
               if (mem_req_o) begin
                  mem_valid_i = (wcnt == 2);
                  wcnt = (wcnt == 2) ? 0 : wcnt + 1;
               end else begin
                  mem_valid_i = 1'b0;
                  wcnt = 0;
               end
            end
            default: mem_valid_i = 1'($urandom_range(0, 1));
         endcase
      end
   end

   sb_t mon_e;
   logic [31:0] mon_a;
   // Monitor: pops the scoreboard on every hit and the address queue on every beat
   always @(negedge clk) begin
      if (instr_valid_o === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_hit addr=%h instr_o=%h required no instr_valid_o", addr_i, instr_o);
         end else begin
            mon_e = sb_q.pop_front();
            if (instr_o !== mon_e.data) begin
               failures++;
               $display("FAIL fetch_data addr=%h instr_o=%h required %h", mon_e.addr, instr_o, mon_e.data);
            end else
               $display("txn fetch addr=%h instr=%h ok", mon_e.addr, instr_o);
         end
      end
      if (mem_req_o === 1'b1 && mem_valid_i === 1'b1) begin
         checks++;
         if (maddr_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat mem_addr_o=%h required no refill beat", mem_addr_o);
         end else begin
            mon_a = maddr_q.pop_front();
            if (mem_addr_o !== mon_a) begin
               failures++;
               $display("FAIL refill_addr mem_addr_o=%h required %h", mem_addr_o, mon_a);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h required=%h", name, got, exp);
      end
   endtask

   task automatic fetch(input logic [31:0] a);
      bit   exp_hit, done, stall_ok, lat_ok;
      int   lat;
      sb_t  e;
      logic [31:0] line;
      exp_hit = model_access(a);
      e.addr = a;
      e.data = {a[31:2], 2'b00} ^ 32'hA5A5_0000;
      sb_q.push_back(e);
      if (!exp_hit) begin
         line = {a[31:4], 4'b0000};
         for (int i = 0; i < WPL; i++) maddr_q.push_back(line + 32'(i * 4));
      end
      @(posedge clk); #1;
      req_valid_i = 1'b1;
      addr_i      = a;
      lat = 0; done = 1'b0; stall_ok = 1'b1;
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge clk);
         if (instr_valid_o === 1'b1) begin
            done = 1'b1;
            if (stall_o !== 1'b0) stall_ok = 1'b0;
         end else begin
            if (stall_o !== 1'b1) stall_ok = 1'b0;
            if (lat == 0 && !exp_hit) check("miss_instr", instr_o, 32'hDEADBEEF);
            lat++;
         end
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL fetch_timeout addr=%h got no instr_valid_o required within 400 cycles", a);
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $fatal(1, "fetch timeout");
      end
      checks++;
      if (!stall_ok) begin
         failures++;
         $display("FAIL stall_shape addr=%h stall_o not high exactly while waiting", a);
      end
      if (exp_hit)            lat_ok = (lat == 0);
      else if (mem_mode == 0) lat_ok = (lat == WPL + 1);
      else if (mem_mode == 1) lat_ok = (lat == 3 * WPL + 1);
      else                    lat_ok = (lat >= WPL + 1);
      checks++;
      if (!lat_ok) begin
         failures++;
         $display("FAIL latency addr=%h got=%0d cycles required %s (mode %0d)", a, lat,
                  exp_hit ? "0 (hit)" : "miss refill", mem_mode);
      end
      @(posedge clk); #1;
      req_valid_i = 1'b0;
   endtask

   task automatic do_flush();
      @(posedge clk); #1; flush_i = 1'b1;
      @(posedge clk); #1; flush_i = 1'b0;
      model_flush();
      $display("txn flush");
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      rst = 1'b1; req_valid_i = 1'b0; flush_i = 1'b0; addr_i = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_mem_req", 32'(mem_req_o), 32'd0);
      check("reset_instr_valid", 32'(instr_valid_o), 32'd0);
      check("reset_stall_idle", 32'(stall_o), 32'd0);

      // Cold miss and refill, then same-line hits
      mem_mode = 0;
      fetch(32'h100);
      fetch(32'h10C);
      fetch(32'h104);
      fetch(32'h108);

      // LRU eviction in set 5: fill A..D, touch A, E evicts B
      do_flush();
      for (int t = 1; t <= 4; t++) fetch((32'(t) << 10) | (32'd5 << 4));
      fetch((32'd1 << 10) | (32'd5 << 4));
      fetch((32'd5 << 10) | (32'd5 << 4));
      fetch((32'd1 << 10) | (32'd5 << 4));
      fetch((32'd3 << 10) | (32'd5 << 4));
      fetch((32'd4 << 10) | (32'd5 << 4));
      fetch((32'd2 << 10) | (32'd5 << 4));

      // Wait states: one beat every third cycle
      mem_mode = 1;
      fetch(32'h300);
      fetch(32'h304);
      fetch(32'h308);
      fetch(32'h30C);
      mem_mode = 0;

      // Flush on the 2nd refill beat
      fetch(32'h2000);
      fetch(32'h100);
      maddr_q.push_back(32'h140);
      maddr_q.push_back(32'h144);
      @(posedge clk); #1; req_valid_i = 1'b1; addr_i = 32'h140;
      @(posedge clk); #1; req_valid_i = 1'b0;
      @(posedge clk); #1; flush_i = 1'b1;
      @(posedge clk); #1; flush_i = 1'b0;
      model_flush();
      @(negedge clk);
      check("flush_abort_mem_req", 32'(mem_req_o), 32'd0);
      check("flush_abort_stall", 32'(stall_o), 32'd0);
      check("flush_abort_beats", 32'(maddr_q.size()), 32'd0);
      $display("txn flush_abort");
      fetch(32'h100);
      fetch(32'h140);
      fetch(32'h2000);

      // Reset on the 3rd refill beat
      fetch(32'h30C);
      maddr_q.push_back(32'h500);
      maddr_q.push_back(32'h504);
      maddr_q.push_back(32'h508);
      @(posedge clk); #1; req_valid_i = 1'b1; addr_i = 32'h500;
      @(posedge clk); #1; req_valid_i = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      model_reset();
      @(negedge clk);
      check("reset_abort_mem_req", 32'(mem_req_o), 32'd0);
      check("reset_abort_stall", 32'(stall_o), 32'd0);
      check("reset_abort_beats", 32'(maddr_q.size()), 32'd0);
      $display("txn reset_abort");
      fetch(32'h100);
      fetch(32'h2000);
      fetch(32'h30C);
      fetch(32'h500);

      // Randomised traffic: 6 tags over 3 sets, random wait modes and flushes
      for (int n = 0; n < 200; n++) begin
         mem_mode = int'($urandom_range(0, 2));
         if ($urandom_range(0, 11) == 0) do_flush();
         a = (32'($urandom_range(0, 5)) << 10) | (32'($urandom_range(0, 2)) << 4)
           | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         fetch(a);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      check("refill_queue_drained", 32'(maddr_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/l1_nway_instr_cache.md
# l1_nway_instr_cache

Parametrised N-way set-associative L1 instruction cache with multi-word lines, true-LRU replacement and a handshaked line-refill state machine. It sits between the fetch stage and instruction memory. Hits return in the same cycle. On a miss it stalls fetch, refills the whole line one word per memory beat, and then serves the request. It also supports a one-cycle global flush for fence.i and self-modifying code.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, instruction word width; fixed at 32, byte offset is 2 bits
- NUM_SETS, 64, sets; power of two, ≥2
- NUM_WAYS, 4, ways per set; power of two, 2..8
- WORDS_PER_LINE, 4, words per line; power of two, ≥1

Derived:
- WOFF_BITS = log2(WORDS_PER_LINE)
- IDX_BITS = log2(NUM_SETS)
- TAG_BITS = ADDR_WIDTH − IDX_BITS − WOFF_BITS − 2
- Address split: tag | index | word offset | 2'b00

Ports:
- clk, in, 1, clock; all state updates on the rising edge
- rst, in, 1, synchronous active-high reset
- req_valid_i, in, 1, fetch request valid this cycle
- addr_i, in, ADDR_WIDTH, fetch byte address; bits [1:0] ignored
- flush_i, in, 1, invalidates all lines
- instr_o, out, DATA_WIDTH, instruction read out; valid only when instr_valid_o=1
- instr_valid_o, out, 1, hit this cycle
- stall_o, out, 1, fetch must hold addr_i
- mem_req_o, out, 1, refill word request
- mem_addr_o, out, ADDR_WIDTH, word-aligned refill address
- mem_data_i, in, DATA_WIDTH, refill data
- mem_valid_i, in, 1, mem_data_i valid; accepted only while mem_req_o=1

## Operation
- Per way and set the cache holds: valid bit, tag, WORDS_PER_LINE data words, and a log2(NUM_WAYS)-bit age.
- **Lookup** (combinational, state IDLE only):
  - hit = req_valid_i && any way is valid with a matching tag.
  - instr_o = that way's word at the word offset.
  - On a miss, instr_o = 32'hDEADBEEF.
- **True LRU.** Ages within a set always form a permutation of 0..NUM_WAYS−1; 0 is MRU.
  - On a touch of way w: every way whose age is below age[w] increments, and age[w] becomes 0.
  - A touch happens on a hit (IDLE, no flush) and on a line install.
- **Victim selection:**
  - The lowest-index invalid way.
  - If every way is valid, the way with age NUM_WAYS−1.
  - The victim is latched on the miss cycle.
- **FSM, IDLE:**
  - req_valid_i && !hit && !flush_i: latch line base address, index and victim; clear cnt; go to REFILL.
- **FSM, REFILL:**
  - mem_req_o=1 and mem_addr_o = {line base, cnt, 2'b00}.
  - On each mem_valid_i: write mem_data_i into the victim's data word cnt, then cnt++.
  - On the beat where cnt = WORDS_PER_LINE−1: write the tag, set valid, touch the victim, and go to IDLE.
  - The refill address is fixed from the latched base; addr_i is ignored during REFILL.
  - The victim's valid bit is cleared on entry to REFILL, so a partial line is never hit.
- **Flush:**
  - flush_i clears every valid bit on the next edge. Ages are unchanged.
  - In REFILL, flush aborts the refill: no install, return to IDLE, cnt = 0.
  - flush_i has priority over a same-cycle hit LRU update and over a same-cycle install.
- **stall_o** = (state==REFILL) || (req_valid_i && !hit).

## Timing
- **Reset** (rst high at an edge):
  - state IDLE, cnt 0, all valid bits 0.
  - Ages in every set: age[w] = w.
  - Latched registers 0.
  - Tag and data arrays are not reset.
- **Reset mid-refill:** the same as reset; the line is not installed; mem_req_o is 0 in the first cycle after the reset edge.
- **Outputs after reset:**
  - mem_req_o=0.
  - instr_valid_o=0.
  - stall_o = req_valid_i (every line is invalid, so any request misses).
- **Hit latency:** 0 cycles; instr_o and instr_valid_o are combinational from addr_i in the same cycle.
- **Miss latency:**
  - Miss cycle, then REFILL from the next cycle.
  - N = WORDS_PER_LINE beats, each completing on an edge with mem_valid_i=1; memory may insert any number of wait cycles.
  - After the last beat the state is IDLE and the held request hits in that cycle.
  - Minimum miss penalty is WORDS_PER_LINE+1 cycles.
- **Memory handshake:**
  - mem_data_i is sampled only when mem_req_o && mem_valid_i.
  - mem_valid_i while mem_req_o=0 is ignored.
- **Wrap-around:** cnt wraps only at the end of a refill. Ages saturate implicitly because the permutation is preserved; there is no counter overflow.

## Test plan
- **Cold miss and refill** (NUM_WAYS=4, WORDS_PER_LINE=4, memory returns addr^32'hA5A5_0000 with 0 wait states), fetch 0x100:
  - stall_o=1 for 5 cycles.
  - mem_addr_o takes 0x100, 0x104, 0x108, 0x10C.
  - Then instr_valid_o=1 and instr_o=0xA5A5_0100.
  - Fetch 0x10C hits in 0 cycles with 0xA5A5_010C.
- **LRU eviction:**
  - Fill one set with tags A,B,C,D, touch A, then miss on E.
  - The way holding B is replaced.
  - A, C and D still hit; B misses.
- **Wait states:** mem_valid_i high only every third cycle. The refill takes 12 cycles and the line data is correct.
- **Flush mid-refill:** flush_i on the 2nd beat.
  - FSM is in IDLE on the next cycle; no line is installed.
  - Previously valid lines in other sets now miss.
- **Reset mid-refill:** rst on the 3rd beat.
  - The next cycle has mem_req_o=0.
  - All fetches miss.
  - Ages in set 0 are {0,1,2,3}.
